// File: rtl/data_mem_bridge.sv
// Data-memory responder for the pipelined RSA core.
// Serves the core load/store port from a word-addressed RAM, gates the core
// with cpu_start, and exposes a host request/ready port for preloading
// operands and reading results. A run ends on a store to the mailbox word
// (last RAM word) or after MAX_CYCLES cycles.
module data_mem_bridge #(
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = 8,
  parameter int MAX_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  // core load/store port
  input  logic              MemWrite,
  input  logic [31:0]       ALUResult,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              cpu_start,
  // run control
  input  logic              run_req,
  output logic              done,
  output logic              timeout,
  // host port
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_wdata,
  output logic [31:0]       host_rdata,
  output logic              host_rvalid
);

  localparam int CNT_W = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            stateNext;
  logic [31:0]       mem [DEPTH];
  logic [CNT_W-1:0]  cycleCnt;

  logic              coreInRange;
  logic [ADDR_W-1:0] coreIdx;
  logic              coreWrite;
  logic              mailboxHit;
  logic              lastCycle;
  logic              runEntry;
  logic              hostAccept;
  logic              hostWrite;
  logic              hostRead;
  logic [1:0]        unusedByteLane;

  // Core address decode; byte-lane bits are don't-care for word accesses.
  always_comb begin
    unusedByteLane = ALUResult[1:0];
    coreIdx        = ALUResult[ADDR_W+1:2];
    coreInRange    = (ALUResult[31:ADDR_W+2] == '0);
    coreWrite      = (state == RUN) && MemWrite && coreInRange;
    mailboxHit     = coreWrite && (coreIdx == '1);
    lastCycle      = (cycleCnt == CNT_LAST);
    runEntry       = (state == IDLE) && run_req;
    hostAccept     = host_valid && host_ready;
    hostWrite      = hostAccept && host_wr;
    hostRead       = hostAccept && !host_wr;
  end

  // Outputs decoded straight from state so reset drops cpu_start without a clock edge.
  always_comb begin
    cpu_start  = (state == RUN);
    done       = (state == DONE);
    host_ready = (state != RUN);
    ReadData   = coreInRange ? mem[coreIdx] : '0;
  end

  // Next-state logic: mailbox store takes priority over the timeout cycle.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (run_req) stateNext = RUN;
      RUN:  if (mailboxHit || lastCycle) stateNext = DONE;
      DONE: if (!run_req) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Run cycle counter and timeout flag; timeout holds through DONE and IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycleCnt <= '0;
      timeout  <= 1'b0;
    end else if (runEntry) begin
      cycleCnt <= '0;
      timeout  <= 1'b0;
    end else if (state == RUN) begin
      if (mailboxHit) begin
        timeout <= 1'b0;
      end else if (lastCycle) begin
        timeout <= 1'b1;
      end else begin
        cycleCnt <= cycleCnt + CNT_W'(1);
      end
    end
  end

  // Host read path: one-cycle latency, rdata holds between reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      host_rvalid <= hostRead;
      if (hostRead) host_rdata <= mem[host_addr];
    end
  end

  // RAM write port; core and host writes are exclusive by state (host_ready is low in RUN).
  always_ff @(posedge clk) begin
    if (reset) begin
      if (coreWrite)      mem[coreIdx]   <= WriteData;
      else if (hostWrite) mem[host_addr] <= host_wdata;
    end
  end

endmodule
